// File: rtl/seg7_scan_decode.sv
// Receive side of a multiplexed 7-segment display: samples the anode enables
// and the a..g segment lines. It waits for each digit to be stable, decodes
// the glyph back to a hex nibble, and hands a 16-bit frame off via valid/ack.
// Ports:
//   clk, reset (sync, active-high)
//   an[3:0] digit enables, an[0] = least significant digit
//   a..g    segment lines
//   value[15:0]    decoded frame {d3,d2,d1,d0}
//   bad_digit[3:0] glyph was not a legal hex pattern
//   out_valid / out_ack  frame handshake
//   overrun  sticky flag: a completed frame was dropped
module seg7_scan_decode #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter bit          SEG_ACT_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    output logic [15:0] value,
    output logic [3:0]  bad_digit,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

    // Returns {bad, nibble}; segment order is {a,b,c,d,e,f,g}.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b1110111: r = 5'h0A;
            7'b0011111: r = 5'h0B;
            7'b1001110: r = 5'h0C;
            7'b0111101: r = 5'h0D;
            7'b1001111: r = 5'h0E;
            7'b1000111: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    logic [10:0]   raw;
    logic [10:0]   s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    sbad_q, sbad_d;
    logic [15:0]   value_q, value_d;
    logic [3:0]    bad_q, bad_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic          match;
    logic          capture;
    logic          frame_done;
    logic          load;
    logic [4:0]    dec;

    // Internal logic is always active-high.
    assign raw = SEG_ACT_LOW ? ~{an, a, b, c, d, e, f, g}
                             :  {an, a, b, c, d, e, f, g};

    always_comb begin
        s_d      = raw;
        cnt_d    = '0;
        seen_d   = seen_q;
        shadow_d = shadow_q;
        sbad_d   = sbad_q;
        value_d  = value_q;
        bad_d    = bad_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;

        match = (raw == s_q);
        if (match) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end

        // Saturating count means a held pattern fires exactly once.
        capture    = match && (cnt_q == CNT_CAP) && $onehot(s_q[10:7]);
        dec        = decode(s_q[6:0]);
        frame_done = &seen_q;
        load       = frame_done && (!valid_q || out_ack);

        if (frame_done) begin
            seen_d = '0;
        end

        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (s_q[7+i]) begin
                    seen_d[i]          = 1'b1;
                    shadow_d[4*i +: 4] = dec[3:0];
                    sbad_d[i]          = dec[4];
                end
            end
        end

        if (load) begin
            value_d = shadow_q;
            bad_d   = sbad_q;
            valid_d = 1'b1;
        end else begin
            if (frame_done) begin
                ovr_d = 1'b1;
            end
            if (out_ack && valid_q) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q      <= '0;
            cnt_q    <= '0;
            seen_q   <= '0;
            shadow_q <= '0;
            sbad_q   <= '0;
            value_q  <= '0;
            bad_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            shadow_q <= shadow_d;
            sbad_q   <= sbad_d;
            value_q  <= value_d;
            bad_q    <= bad_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign value     = value_q;
    assign bad_digit = bad_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule
